// File: rtl/spmv_mem_arbiter_pkg.sv
// Shared constants and helpers for the SpMV PE memory arbiter.
package spmv_mem_arbiter_pkg;

    localparam int MODE_PRIO  = 0;
    localparam int MODE_RR    = 1;
    localparam int TAG_CH_LSB = 0;

    // Channel-index width; a single channel still gets one tag bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/spmv_mem_arbiter_fifo.sv
// Per-channel request FIFO with registered read port and almost-full flag.
module spmv_mem_arbiter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         afull,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          full, wr_en;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign afull = cnt >= (AW+1)'(DEPTH - 4);
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign wr_en = push && (!full || pop);
    assign ovf   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rdata  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= wdata;

endmodule

// File: rtl/spmv_mem_arbiter_rr.sv
// Request arbiter: fixed priority (highest index) or round robin from a rotating pointer.
module spmv_rr_arbiter
    import spmv_mem_arbiter_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int MODE = MODE_PRIO,
    localparam int CH_W = clog2_min1(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NCH-1:0]  req,
    output logic [NCH-1:0]  gnt,
    output logic [CH_W-1:0] gidx
);
    logic [CH_W-1:0] ptr;
    int              c;

    always_comb begin
        gnt  = '0;
        gidx = '0;
        c    = 0;
        if (en) begin
            if (MODE == MODE_RR) begin
                // Walk offsets downward so the smallest offset from ptr is written last.
                for (int i = NCH - 1; i >= 0; i--) begin
                    c = int'(ptr) + i;
                    if (c >= NCH) c = c - NCH;
                    if (req[CH_W'(c)]) begin
                        gnt            = '0;
                        gnt[CH_W'(c)]  = 1'b1;
                        gidx           = CH_W'(c);
                    end
                end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (req[CH_W'(k)]) begin
                        gnt            = '0;
                        gnt[CH_W'(k)]  = 1'b1;
                        gidx           = CH_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (MODE == MODE_RR && |gnt)
            ptr <= (gidx == CH_W'(NCH - 1)) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// N-channel memory request arbiter with per-channel FIFOs and tag-routed load responses.
module spmv_mem_arbiter
    import spmv_mem_arbiter_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64,
    parameter int SUB_W  = 2,
    parameter int DEPTH  = 32,
    parameter int MODE   = MODE_PRIO,
    localparam int CH_W  = clog2_min1(NCH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          ch_req_ld,
    input  logic [NCH-1:0]          ch_req_st,
    input  logic [NCH*ADDR_W-1:0]   ch_req_addr,
    input  logic [NCH*DATA_W-1:0]   ch_req_d_or_tag,
    output logic [NCH-1:0]          ch_req_afull,
    output logic                    req_mem_ld,
    output logic                    req_mem_st,
    output logic [ADDR_W-1:0]       req_mem_addr,
    output logic [DATA_W-1:0]       req_mem_d_or_tag,
    input  logic                    req_mem_stall,
    input  logic                    rsp_mem_push,
    input  logic [CH_W+SUB_W-1:0]   rsp_mem_tag,
    input  logic [DATA_W-1:0]       rsp_mem_q,
    output logic                    rsp_mem_stall,
    output logic [NCH-1:0]          ch_rsp_push,
    output logic [SUB_W-1:0]        ch_rsp_tag,
    output logic [DATA_W-1:0]       ch_rsp_q,
    input  logic [NCH-1:0]          ch_rsp_stall,
    output logic                    busy,
    output logic [1:0]              err
);
    localparam int EW = 1 + ADDR_W + DATA_W;

    logic [NCH-1:0][ADDR_W-1:0] addr_v;
    logic [NCH-1:0][DATA_W-1:0] data_v;
    logic [NCH-1:0][EW-1:0]     q_v;
    logic [NCH-1:0]             empty, ovf, gnt;
    logic [CH_W-1:0]            gidx;

    assign addr_v = ch_req_addr;
    assign data_v = ch_req_d_or_tag;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Store wins when ld and st arrive together.
        spmv_mem_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (ch_req_ld[g] | ch_req_st[g]),
            .wdata ({ch_req_st[g], addr_v[g], data_v[g]}),
            .pop   (gnt[g]),
            .rdata (q_v[g]),
            .empty (empty[g]),
            .afull (ch_req_afull[g]),
            .ovf   (ovf[g])
        );
    end

    spmv_rr_arbiter #(.NCH(NCH), .MODE(MODE)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (!req_mem_stall),
        .req  (~empty),
        .gnt  (gnt),
        .gidx (gidx)
    );

    // vld_pipe[0]: FIFO read data valid (A+1); vld_pipe[1]: issue registered (A+2).
    logic [1:0]        vld_pipe;
    logic [CH_W-1:0]   s1_ch;
    logic              s1_st;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data, ld_tag;

    assign {s1_st, s1_addr, s1_data} = q_v[s1_ch];
    assign ld_tag = DATA_W'({s1_data[SUB_W-1:0], s1_ch});

    logic [CH_W-1:0]  rsp_ch;
    logic [SUB_W-1:0] rsp_sub;
    logic             rsp_ok;

    assign rsp_ch        = rsp_mem_tag[TAG_CH_LSB +: CH_W];
    assign rsp_sub       = rsp_mem_tag[CH_W +: SUB_W];
    assign rsp_ok        = int'(rsp_ch) < NCH;
    assign rsp_mem_stall = |ch_rsp_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe         <= '0;
            s1_ch            <= '0;
            req_mem_ld       <= 1'b0;
            req_mem_st       <= 1'b0;
            req_mem_addr     <= '0;
            req_mem_d_or_tag <= '0;
            ch_rsp_push      <= '0;
            ch_rsp_tag       <= '0;
            ch_rsp_q         <= '0;
            busy             <= 1'b0;
            err              <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], |gnt};
            if (|gnt) s1_ch <= gidx;

            // Once popped, an entry issues regardless of stall; memory absorbs the skid.
            req_mem_ld <= vld_pipe[0] && !s1_st;
            req_mem_st <= vld_pipe[0] && s1_st;
            if (vld_pipe[0]) begin
                req_mem_addr     <= s1_addr;
                req_mem_d_or_tag <= s1_st ? s1_data : ld_tag;
            end

            ch_rsp_push <= (rsp_mem_push && rsp_ok) ? (NCH'(1) << rsp_ch) : '0;
            if (rsp_mem_push && rsp_ok) begin
                ch_rsp_tag <= rsp_sub;
                ch_rsp_q   <= rsp_mem_q;
            end

            err  <= err | {rsp_mem_push && !rsp_ok, |ovf};
            busy <= (|(~empty)) || (|vld_pipe) || (|ch_rsp_push);
        end
    end

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Random + directed bench: both arbitration modes against a queue-based reference model.
module tb_spmv_mem_arbiter;
    localparam int NCH = 3, ADDR_W = 48, DATA_W = 64, SUB_W = 2, DEPTH = 32;
    localparam int CH_W = 2, TW = CH_W + SUB_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NCH-1:0]        ch_req_ld, ch_req_st, ch_rsp_stall;
    logic [NCH*ADDR_W-1:0] ch_req_addr;
    logic [NCH*DATA_W-1:0] ch_req_d_or_tag;
    logic                  req_mem_stall, rsp_mem_push;
    logic [TW-1:0]         rsp_mem_tag;
    logic [DATA_W-1:0]     rsp_mem_q;

    logic [NCH-1:0]    afull_o [2];
    logic              ld_o [2], st_o [2], rstall_o [2], busy_o [2];
    logic [ADDR_W-1:0] addr_o [2];
    logic [DATA_W-1:0] dt_o [2], rq_o [2];
    logic [NCH-1:0]    rpush_o [2];
    logic [SUB_W-1:0]  rtag_o [2];
    logic [1:0]        err_o [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spmv_mem_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUB_W(SUB_W),
                           .DEPTH(DEPTH), .MODE(g)) u_dut (
            .clk(clk), .rst(rst),
            .ch_req_ld(ch_req_ld), .ch_req_st(ch_req_st),
            .ch_req_addr(ch_req_addr), .ch_req_d_or_tag(ch_req_d_or_tag),
            .ch_req_afull(afull_o[g]),
            .req_mem_ld(ld_o[g]), .req_mem_st(st_o[g]),
            .req_mem_addr(addr_o[g]), .req_mem_d_or_tag(dt_o[g]),
            .req_mem_stall(req_mem_stall),
            .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
            .rsp_mem_stall(rstall_o[g]),
            .ch_rsp_push(rpush_o[g]), .ch_rsp_tag(rtag_o[g]), .ch_rsp_q(rq_o[g]),
            .ch_rsp_stall(ch_rsp_stall),
            .busy(busy_o[g]), .err(err_o[g])
        );
    end

    typedef struct { logic st; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ent_t;
    typedef struct { logic st; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] dt; int t; } iss_t;

    ent_t              fq [2*NCH][$];
    iss_t              xq [2][$];
    int                ptr [2];
    logic [1:0]        x_err [2];
    logic [NCH-1:0]    x_rpush;
    logic [SUB_W-1:0]  x_rtag;
    logic [DATA_W-1:0] x_rq;
    logic [ADDR_W-1:0] got [2][$];
    int                n_iss [2];
    int                now, n_chk, n_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h expected %0h", tag, now, act, exp);
        end
    endtask

    task automatic check();
        for (int m = 0; m < 2; m++) begin
            logic           xv;
            logic [NCH-1:0] xa;
            xv = xq[m].size() > 0 && xq[m][0].t + 1 == now;
            chk($sformatf("m%0d issue_vld", m), 64'(ld_o[m] | st_o[m]), 64'(xv));
            if (xv) begin
                iss_t s;
                s = xq[m].pop_front();
                chk($sformatf("m%0d issue_ld", m), 64'(ld_o[m]), 64'(!s.st));
                chk($sformatf("m%0d issue_st", m), 64'(st_o[m]), 64'(s.st));
                chk($sformatf("m%0d issue_addr", m), 64'(addr_o[m]), 64'(s.a));
                chk($sformatf("m%0d issue_data", m), dt_o[m], s.dt);
            end
            if (ld_o[m] | st_o[m]) begin
                n_iss[m]++;
                got[m].push_back(addr_o[m]);
            end
            for (int c = 0; c < NCH; c++) xa[c] = fq[m*NCH+c].size() >= DEPTH - 4;
            chk($sformatf("m%0d afull", m), 64'(afull_o[m]), 64'(xa));
            chk($sformatf("m%0d err", m), 64'(err_o[m]), 64'(x_err[m]));
            chk($sformatf("m%0d rsp_push", m), 64'(rpush_o[m]), 64'(x_rpush));
            if (x_rpush != '0) begin
                chk($sformatf("m%0d rsp_tag", m), 64'(rtag_o[m]), 64'(x_rtag));
                chk($sformatf("m%0d rsp_q", m), rq_o[m], x_rq);
            end
            chk($sformatf("m%0d rsp_stall", m), 64'(rstall_o[m]), 64'(|ch_rsp_stall));
        end
    endtask

    task automatic cycle(input logic r, input logic [NCH-1:0] ld, input logic [NCH-1:0] st,
                         input logic [NCH*ADDR_W-1:0] a, input logic [NCH*DATA_W-1:0] d,
                         input logic stall, input logic rp, input logic [TW-1:0] rt,
                         input logic [DATA_W-1:0] rq, input logic [NCH-1:0] rs);
        rst = r; ch_req_ld = ld; ch_req_st = st; ch_req_addr = a; ch_req_d_or_tag = d;
        req_mem_stall = stall; rsp_mem_push = rp; rsp_mem_tag = rt; rsp_mem_q = rq;
        ch_rsp_stall = rs;
        now++;
        if (r) begin
            for (int i = 0; i < 2*NCH; i++) fq[i].delete();
            for (int m = 0; m < 2; m++) begin
                xq[m].delete(); ptr[m] = 0; x_err[m] = '0;
            end
            x_rpush = '0; x_rtag = '0; x_rq = '0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                int g;
                g = -1;
                if (!stall) begin
                    if (m == 0) begin
                        for (int c = NCH - 1; c >= 0; c--)
                            if (g < 0 && fq[m*NCH+c].size() > 0) g = c;
                    end else begin
                        for (int i = 0; i < NCH; i++)
                            if (g < 0 && fq[m*NCH + (ptr[m]+i) % NCH].size() > 0) g = (ptr[m]+i) % NCH;
                    end
                end
                if (g >= 0) begin
                    ent_t e;
                    iss_t s;
                    e = fq[m*NCH+g].pop_front();
                    s.st = e.st; s.a = e.a; s.t = now;
                    s.dt = e.st ? e.d : ((64'(e.d[SUB_W-1:0]) << CH_W) | 64'(g));
                    xq[m].push_back(s);
                    if (m == 1) ptr[m] = (g + 1) % NCH;
                end
                for (int c = 0; c < NCH; c++) begin
                    if (ld[c] | st[c]) begin
                        ent_t e;
                        e.st = st[c]; e.a = a[c*ADDR_W +: ADDR_W]; e.d = d[c*DATA_W +: DATA_W];
                        if (fq[m*NCH+c].size() < DEPTH) fq[m*NCH+c].push_back(e);
                        else x_err[m][0] = 1'b1;
                    end
                end
            end
            x_rpush = '0;
            if (rp) begin
                if (int'(rt[CH_W-1:0]) < NCH) begin
                    x_rpush[rt[CH_W-1:0]] = 1'b1;
                    x_rtag = rt[TW-1:CH_W];
                    x_rq   = rq;
                end else begin
                    x_err[0][1] = 1'b1; x_err[1][1] = 1'b1;
                end
            end
        end
        @(negedge clk);
        check();
    endtask

    task automatic idle(input int n, input logic stall);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0, stall, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        cycle(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d rst ld", m), 64'(ld_o[m]), 64'd0);
            chk($sformatf("m%0d rst st", m), 64'(st_o[m]), 64'd0);
            chk($sformatf("m%0d rst addr", m), 64'(addr_o[m]), 64'd0);
            chk($sformatf("m%0d rst data", m), dt_o[m], 64'd0);
            chk($sformatf("m%0d rst rsp_tag", m), 64'(rtag_o[m]), 64'd0);
            chk($sformatf("m%0d rst rsp_q", m), rq_o[m], 64'd0);
            chk($sformatf("m%0d rst busy", m), 64'(busy_o[m]), 64'd0);
            got[m].delete(); n_iss[m] = 0;
        end
    endtask

    logic [NCH*ADDR_W-1:0] va;
    logic [NCH*DATA_W-1:0] vd;
    logic [NCH-1:0]        vl, vs;
    logic [ADDR_W-1:0]     exp0 [6], exp1 [6];

    initial begin
        n_chk = 0; n_err = 0; now = 0;
        for (int m = 0; m < 2; m++) begin ptr[m] = 0; x_err[m] = '0; n_iss[m] = 0; end
        x_rpush = '0; x_rtag = '0; x_rq = '0;
        do_reset();
        do_reset();

        // Load on ch0, sub-tag 2: issued two cycles after the pop with tag 0x8.
        va = '0; vd = '0;
        va[0 +: ADDR_W] = 48'h100; vd[0 +: DATA_W] = 64'd2;
        cycle(1'b0, 3'b001, 3'b000, va, vd, 1'b0, 1'b0, '0, '0, '0);
        idle(2, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d t1 ld", m), 64'(ld_o[m]), 64'd1);
            chk($sformatf("m%0d t1 addr", m), 64'(addr_o[m]), 64'h100);
            chk($sformatf("m%0d t1 tag", m), dt_o[m], 64'h8);
            chk($sformatf("m%0d t1 busy", m), 64'(busy_o[m]), 64'd1);
        end
        idle(5, 1'b0);
        for (int m = 0; m < 2; m++) chk($sformatf("m%0d t1 idle busy", m), 64'(busy_o[m]), 64'd0);

        // Arbitration order with two stores queued per channel.
        do_reset();
        va = '0;
        for (int c = 0; c < NCH; c++) va[c*ADDR_W +: ADDR_W] = ADDR_W'(16 + c);
        cycle(1'b0, '0, 3'b111, va, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int c = 0; c < NCH; c++) va[c*ADDR_W +: ADDR_W] = ADDR_W'(32 + c);
        cycle(1'b0, '0, 3'b111, va, '0, 1'b0, 1'b0, '0, '0, '0);
        idle(8, 1'b0);
        exp0 = '{48'h12, 48'h22, 48'h11, 48'h21, 48'h10, 48'h20};
        exp1 = '{48'h10, 48'h11, 48'h12, 48'h20, 48'h21, 48'h22};
        chk("t2 m0 count", 64'(got[0].size()), 64'd6);
        chk("t2 m1 count", 64'(got[1].size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got[0].size()) chk($sformatf("t2 m0 order%0d", i), 64'(got[0][i]), 64'(exp0[i]));
            if (i < got[1].size()) chk($sformatf("t2 m1 order%0d", i), 64'(got[1][i]), 64'(exp1[i]));
        end

        // Stall with three queued: only the already-popped entry may issue.
        do_reset();
        cycle(1'b0, '0, 3'b111, va, '0, 1'b0, 1'b0, '0, '0, '0);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int m = 0; m < 2; m++) n_iss[m] = 0;
        idle(10, 1'b1);
        for (int m = 0; m < 2; m++) chk($sformatf("m%0d t3 stalled issues<=2", m), 64'(n_iss[m] <= 2), 64'd1);
        idle(10, 1'b0);
        for (int m = 0; m < 2; m++) chk($sformatf("m%0d t3 total", m), 64'(n_iss[m]), 64'd3);

        // Overflow: 33 stores into ch1 while stalled.
        do_reset();
        for (int i = 1; i <= 33; i++) begin
            va = '0; vd = '0;
            va[ADDR_W +: ADDR_W] = ADDR_W'(i); vd[DATA_W +: DATA_W] = DATA_W'(i * 3);
            cycle(1'b0, '0, 3'b010, va, vd, 1'b1, 1'b0, '0, '0, '0);
            if (i == 27 || i == 28)
                for (int m = 0; m < 2; m++)
                    chk($sformatf("m%0d t4 afull push%0d", m, i), 64'(afull_o[m][1]), 64'(i == 28));
        end
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d t4 err0", m), 64'(err_o[m][0]), 64'd1);
            n_iss[m] = 0;
        end
        idle(40, 1'b0);
        for (int m = 0; m < 2; m++) chk($sformatf("m%0d t4 drained", m), 64'(n_iss[m]), 64'd32);

        // Response routing and bad channel tag.
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 4'h5, 64'hDEAD, '0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d t5 push", m), 64'(rpush_o[m]), 64'b010);
            chk($sformatf("m%0d t5 tag", m), 64'(rtag_o[m]), 64'd1);
            chk($sformatf("m%0d t5 q", m), rq_o[m], 64'hDEAD);
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 4'h3, 64'hBEEF, '0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d t5 badtag push", m), 64'(rpush_o[m]), 64'd0);
            chk($sformatf("m%0d t5 err1", m), 64'(err_o[m][1]), 64'd1);
        end

        // Reset with five queued and one in flight: nothing issues afterwards.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            va = '0;
            va[(i % NCH)*ADDR_W +: ADDR_W] = ADDR_W'(64 + i);
            cycle(1'b0, '0, 3'(1 << (i % NCH)), va, '0, 1'b1, 1'b0, '0, '0, '0);
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        do_reset();
        idle(10, 1'b0);
        for (int m = 0; m < 2; m++) chk($sformatf("m%0d t6 no issue", m), 64'(n_iss[m]), 64'd0);

        // Randomised traffic, light then heavy load.
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                for (int c = 0; c < NCH; c++) begin
                    int r;
                    r = $urandom_range(0, 99);
                    vl[c] = r < (ph ? 25 : 10);
                    vs[c] = r >= (ph ? 15 : 5) && r < (ph ? 45 : 20);
                    va[c*ADDR_W +: ADDR_W] = ADDR_W'({$urandom, $urandom});
                    vd[c*DATA_W +: DATA_W] = {$urandom, $urandom};
                end
                cycle(1'b0, vl, vs, va, vd, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      TW'($urandom_range(0, 15)), {$urandom, $urandom}, NCH'($urandom));
            end
        end
        idle(120, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d rnd pending", m), 64'(xq[m].size()), 64'd0);
            chk($sformatf("m%0d rnd busy", m), 64'(busy_o[m]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
